// File: rtl/capture_ctrl_pkg.sv
// Shared types and helpers for the scope capture sequencer (package scope_pkg).
package scope_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_TRIG,
    POST,
    READY
  } cap_state_t;

  // Level crossing test; slope 0 = rising, 1 = falling.
  function automatic logic crossed(
    input logic [SAMPLE_W-1:0] prev,
    input logic [SAMPLE_W-1:0] cur,
    input logic [SAMPLE_W-1:0] lvl,
    input logic                falling
  );
    if (falling) return (prev > lvl) && (cur <= lvl);
    else         return (prev < lvl) && (cur >= lvl);
  endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Control, sample stream, RAM write port and readout handshake of capture_ctrl.
interface capture_ctrl_if #(
  parameter int AW = 11
);
  import scope_pkg::*;

  logic                arm;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] trig_level;
  logic                trig_slope;
  logic [AW-1:0]       pre_count;
  logic                rd_done;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [SAMPLE_W-1:0] wr_data;
  logic [AW-1:0]       start_addr;
  logic                buf_ready;
  logic                busy;
  logic                forced;

  modport master (
    output arm, sample_valid, sample, trig_level, trig_slope, pre_count, rd_done,
    input  wr_en, wr_addr, wr_data, start_addr, buf_ready, busy, forced
  );

  modport slave (
    input  arm, sample_valid, sample, trig_level, trig_slope, pre_count, rd_done,
    output wr_en, wr_addr, wr_data, start_addr, buf_ready, busy, forced
  );

endinterface

// File: rtl/capture_ctrl_trig_detect.sv
// Previous-sample register and slope compare; hit is combinational on the current sample.
module trig_detect
  import scope_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                slope,
  input  logic                eval,
  output logic                hit
);

  logic [SAMPLE_W-1:0] prev;
  logic                prev_vld;

  // prev_vld drops at arm so the first sample after arm never sees stale history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (clear) begin
      prev_vld <= 1'b0;
    end else if (sample_valid) begin
      prev     <= sample;
      prev_vld <= 1'b1;
    end
  end

  assign hit = eval && sample_valid && prev_vld && crossed(prev, sample, level, slope);

endmodule

// File: rtl/capture_ctrl.sv
// Trigger/capture sequencer for the scope sample ring buffer.
// Optional auto-trigger timeout is built in when CAPTURE_AUTO_TRIG_EN is defined.
module capture_ctrl
  import scope_pkg::*;
#(
  parameter int DEPTH   = 2048,
  parameter int AW      = 11,
  parameter int TIMEOUT = 65535
) (
  input logic           osc_clk,
  input logic           reset,
  capture_ctrl_if.slave bus
);

  cap_state_t          state;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [SAMPLE_W-1:0] wr_data;
  logic [AW-1:0]       start_addr;
  logic                buf_ready;
  logic                busy;
  logic                forced;

  logic [AW-1:0]       pre_lat;
  logic [AW-1:0]       cnt;
  logic [AW-1:0]       rem;
  logic [AW-1:0]       trig_addr;
  logic [SAMPLE_W-1:0] lvl;
  logic                slope;

  logic                write;
  logic                hit;
  logic                fire;
  logic                forced_fire;
  logic [AW-1:0]       cur_addr;
  logic [AW-1:0]       post_len;

  function automatic logic [AW-1:0] clamp_pre(input logic [AW-1:0] p);
    if (32'(p) > 32'(DEPTH - 1)) return AW'(DEPTH - 1);
    else                         return p;
  endfunction

  assign write    = bus.sample_valid && (state == ARM || state == WAIT_TRIG || state == POST);
  // Address the current sample will land on, accounting for a write still in flight.
  assign cur_addr = wr_addr + AW'(wr_en);
  assign post_len = AW'(DEPTH - 1) - pre_lat;

  trig_detect u_trig (
    .clk          (osc_clk),
    .rst_n        (reset),
    .clear        (state == IDLE && bus.arm),
    .sample_valid (bus.sample_valid),
    .sample       (bus.sample),
    .level        (lvl),
    .slope        (slope),
    .eval         (state == WAIT_TRIG),
    .hit          (hit)
  );

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo;

  assign tmo = (tmo_cnt == TW'(TIMEOUT));

  // Counts only while waiting for a trigger and saturates at the timeout.
  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state != WAIT_TRIG) begin
      tmo_cnt <= '0;
    end else if (!tmo) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign fire        = hit || (tmo && bus.sample_valid);
  assign forced_fire = !hit;
`else
  assign fire        = hit;
  assign forced_fire = 1'b0;
`endif

  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      start_addr <= '0;
      buf_ready  <= 1'b0;
      busy       <= 1'b0;
      forced     <= 1'b0;
      pre_lat    <= '0;
      cnt        <= '0;
      rem        <= '0;
      trig_addr  <= '0;
      lvl        <= '0;
      slope      <= 1'b0;
    end else begin
      // Write port: address post-increments after each strobe.
      wr_en <= write;
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      if (write) wr_data <= bus.sample;

      case (state)
        IDLE: begin
          if (bus.arm) begin
            state   <= ARM;
            busy    <= 1'b1;
            forced  <= 1'b0;
            cnt     <= '0;
            pre_lat <= clamp_pre(bus.pre_count);
            lvl     <= bus.trig_level;
            slope   <= bus.trig_slope;
          end
        end

        ARM: begin
          if (cnt == pre_lat) begin
            state <= WAIT_TRIG;
          end else if (bus.sample_valid) begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_TRIG: begin
          if (fire) begin
            trig_addr <= cur_addr;
            forced    <= forced_fire;
            // With a full pre-trigger history the trigger sample closes the frame.
            if (post_len == '0) begin
              state      <= READY;
              buf_ready  <= 1'b1;
              start_addr <= cur_addr - pre_lat;
            end else begin
              state <= POST;
              rem   <= post_len;
            end
          end
        end

        POST: begin
          if (bus.sample_valid) begin
            rem <= rem - 1'b1;
            if (rem == AW'(1)) begin
              state      <= READY;
              buf_ready  <= 1'b1;
              start_addr <= trig_addr - pre_lat;
            end
          end
        end

        READY: begin
          if (bus.rd_done) begin
            state     <= IDLE;
            buf_ready <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          buf_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_en      = wr_en;
  assign bus.wr_addr    = wr_addr;
  assign bus.wr_data    = wr_data;
  assign bus.start_addr = start_addr;
  assign bus.buf_ready  = buf_ready;
  assign bus.busy       = busy;
  assign bus.forced     = forced;

endmodule
